// File: rtl/count_seq_decoder.sv
// Locks onto a 3-bit counter stream (binary or Gray order), reports the decoded
// sequence index, flags illegal steps, mode switches and wraps, and counts errors.
module count_seq_decoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             locked,
  output logic             mode,
  output logic [2:0]       dec_value,
  output logic             parity_flag,
  output logic             seq_err,
  output logic             mode_chg,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HAVE1 = 2'd1,
    BIN   = 2'd2,
    GRAY  = 2'd3
  } state_e;

  function automatic logic [2:0] bin_next(input logic [2:0] x);
    return x + 3'd1;
  endfunction

  function automatic logic [2:0] gray_next(input logic [2:0] x);
    logic [2:0] n;
    case (x)
      3'd0:    n = 3'd1;
      3'd1:    n = 3'd3;
      3'd3:    n = 3'd2;
      3'd2:    n = 3'd6;
      3'd6:    n = 3'd7;
      3'd7:    n = 3'd5;
      3'd5:    n = 3'd4;
      default: n = 3'd0;  // 4 -> 0
    endcase
    return n;
  endfunction

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic             locked_d, mode_d, parity_d;
  logic             seq_err_d, mode_chg_d, wrap_d;
  logic [2:0]       dec_d;
  logic [ERR_W-1:0] err_d;
  logic             bin_hit, gray_hit;

  // Neither successor function maps a value to itself, so a repeated sample
  // naturally falls out as "no match".
  assign bin_hit  = (in_code == bin_next(prev_q));
  assign gray_hit = (in_code == gray_next(prev_q));

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    dec_d      = dec_value;
    parity_d   = parity_flag;
    seq_err_d  = 1'b0;
    mode_chg_d = 1'b0;
    wrap_d     = 1'b0;
    err_d      = err_count;

    if (clr) begin
      state_d = IDLE;
      err_d   = '0;
    end else if (in_valid) begin
      prev_d   = in_code;
      parity_d = ^in_code;
      case (state_q)
        IDLE: state_d = HAVE1;
        HAVE1: begin
          if (bin_hit && !gray_hit)      state_d = BIN;
          else if (gray_hit && !bin_hit) state_d = GRAY;
          else if (!bin_hit && !gray_hit) seq_err_d = 1'b1;
        end
        // The match for the current mode is tested first so ambiguous steps
        // (0->1, 6->7) never flip the mode.
        BIN: begin
          if (bin_hit) state_d = BIN;
          else if (gray_hit) begin
            state_d    = GRAY;
            mode_chg_d = 1'b1;
          end else begin
            state_d   = HAVE1;
            seq_err_d = 1'b1;
          end
        end
        default: begin  // GRAY
          if (gray_hit) state_d = GRAY;
          else if (bin_hit) begin
            state_d    = BIN;
            mode_chg_d = 1'b1;
          end else begin
            state_d   = HAVE1;
            seq_err_d = 1'b1;
          end
        end
      endcase

      dec_d  = (state_d == GRAY) ? gray2bin(in_code) : in_code;
      wrap_d = (state_q == BIN || state_q == GRAY) && (state_d == state_q) &&
               (dec_value == 3'd7) && (dec_d == 3'd0);

      if (seq_err_d && (err_count != '1)) err_d = err_count + ERR_W'(1);
    end

    locked_d = (state_d == BIN) || (state_d == GRAY);
    mode_d   = (state_d == GRAY);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      locked      <= 1'b0;
      mode        <= 1'b0;
      dec_value   <= '0;
      parity_flag <= 1'b0;
      seq_err     <= 1'b0;
      mode_chg    <= 1'b0;
      wrap        <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      locked      <= locked_d;
      mode        <= mode_d;
      dec_value   <= dec_d;
      parity_flag <= parity_d;
      seq_err     <= seq_err_d;
      mode_chg    <= mode_chg_d;
      wrap        <= wrap_d;
      err_count   <= err_d;
    end
  end

endmodule

// File: tb/tb_count_seq_decoder.sv
// Directed bench for count_seq_decoder: expected output sets are queued as each
// sample is driven and popped for comparison once the registered response appears.
module tb_count_seq_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = '0;
  logic       locked, mode, parity_flag, seq_err, mode_chg, wrap;
  logic [2:0] dec_value;
  logic [7:0] err_count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic       lk;
    logic       md;
    logic [2:0] dec;
    logic       par;
    logic       se;
    logic       mc;
    logic       wr;
    logic [7:0] ec;
  } exp_t;

  exp_t exp_q[$];

  count_seq_decoder #(.ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .locked     (locked),
    .mode       (mode),
    .dec_value  (dec_value),
    .parity_flag(parity_flag),
    .seq_err    (seq_err),
    .mode_chg   (mode_chg),
    .wrap       (wrap),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input bit lk, input bit md, input int dec, input bit par,
                              input bit se, input bit mc, input bit wr, input int ec);
    exp_t e;
    e.lk  = lk;
    e.md  = md;
    e.dec = 3'(dec);
    e.par = par;
    e.se  = se;
    e.mc  = mc;
    e.wr  = wr;
    e.ec  = 8'(ec);
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s observed=no-entry expected=scoreboard-entry", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, ".locked"},    8'(locked),      8'(e.lk));
    cmp({tag, ".mode"},      8'(mode),        8'(e.md));
    cmp({tag, ".dec_value"}, 8'(dec_value),   8'(e.dec));
    cmp({tag, ".parity"},    8'(parity_flag), 8'(e.par));
    cmp({tag, ".seq_err"},   8'(seq_err),     8'(e.se));
    cmp({tag, ".mode_chg"},  8'(mode_chg),    8'(e.mc));
    cmp({tag, ".wrap"},      8'(wrap),        8'(e.wr));
    cmp({tag, ".err_count"}, err_count,       e.ec);
  endtask

  // Drive one cycle of stimulus on the falling edge, check just after the rising edge.
  task automatic step(input string tag, input bit c, input bit v, input logic [2:0] code,
                      input exp_t e);
    @(negedge clk);
    clr      = c;
    in_valid = v;
    in_code  = code;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic check_now(input string tag, input exp_t e);
    exp_q.push_back(e);
    check_out(tag);
  endtask

  initial begin
    // Power-up reset, checked asynchronously before any clock edge.
    #2 reset = 1'b1;
    #1 check_now("rst0", mk(0,0,0,0,0,0,0,0));
    @(negedge clk) reset = 1'b0;

    // Binary count 2..7,0 with wrap.
    step("b2",  0,1,3'd2, mk(0,0,2,1,0,0,0,0));
    step("b3",  0,1,3'd3, mk(1,0,3,0,0,0,0,0));
    step("b4",  0,1,3'd4, mk(1,0,4,1,0,0,0,0));
    step("b5",  0,1,3'd5, mk(1,0,5,0,0,0,0,0));
    step("b6",  0,1,3'd6, mk(1,0,6,0,0,0,0,0));
    step("b7",  0,1,3'd7, mk(1,0,7,1,0,0,0,0));
    step("b0",  0,1,3'd0, mk(1,0,0,0,0,0,1,0));
    step("bidle",0,0,3'd3, mk(1,0,0,0,0,0,0,0));

    // Gray count 0,1,3,2,6,7,5,4,0 after a clear.
    step("gclr",0,0,3'd0, mk(1,0,0,0,0,0,0,0));
    step("gclr1",1,0,3'd0, mk(0,0,0,0,0,0,0,0));
    step("g0",  0,1,3'd0, mk(0,0,0,0,0,0,0,0));
    step("g1",  0,1,3'd1, mk(0,0,1,1,0,0,0,0));
    step("g3",  0,1,3'd3, mk(1,1,2,0,0,0,0,0));
    step("g2",  0,1,3'd2, mk(1,1,3,1,0,0,0,0));
    step("g6",  0,1,3'd6, mk(1,1,4,0,0,0,0,0));
    step("g7",  0,1,3'd7, mk(1,1,5,1,0,0,0,0));
    step("g5",  0,1,3'd5, mk(1,1,6,0,0,0,0,0));
    step("g4",  0,1,3'd4, mk(1,1,7,1,0,0,0,0));
    step("gw0", 0,1,3'd0, mk(1,1,0,0,0,0,1,0));

    // Mode switches, ambiguous step in GRAY, repeated value error.
    step("mclr",1,1,3'd5, mk(0,0,0,0,0,0,0,0));
    step("m2",  0,1,3'd2, mk(0,0,2,1,0,0,0,0));
    step("m3",  0,1,3'd3, mk(1,0,3,0,0,0,0,0));
    step("msw", 0,1,3'd2, mk(1,1,3,1,0,1,0,0));
    step("m6",  0,1,3'd6, mk(1,1,4,0,0,0,0,0));
    step("mamb",0,1,3'd7, mk(1,1,5,1,0,0,0,0));
    step("msw2",0,1,3'd0, mk(1,0,0,0,0,1,0,0));
    step("mrep",0,1,3'd0, mk(0,0,0,0,1,0,0,1));

    // Illegal step then saturation of the error counter.
    step("eclr",1,0,3'd0, mk(0,0,0,0,0,0,0,0));
    step("e0",  0,1,3'd0, mk(0,0,0,0,0,0,0,0));
    step("e1",  0,1,3'd1, mk(0,0,1,1,0,0,0,0));
    step("e5",  0,1,3'd5, mk(0,0,5,0,1,0,0,1));
    for (int i = 0; i < 300; i++)
      step("sat", 0,1,3'd5, mk(0,0,5,0,1,0,0, (i + 2 > 255) ? 255 : i + 2));
    step("satidle",0,0,3'd5, mk(0,0,5,0,0,0,0,255));

    // Ambiguous start stays unlocked; clr drops a concurrent sample.
    step("aclr",1,0,3'd0, mk(0,0,5,0,0,0,0,0));
    step("a0",  0,1,3'd0, mk(0,0,0,0,0,0,0,0));
    step("a1",  0,1,3'd1, mk(0,0,1,1,0,0,0,0));
    step("aclrv",1,1,3'd3, mk(0,0,1,1,0,0,0,0));
    step("a3",  0,1,3'd3, mk(0,0,3,0,0,0,0,0));
    step("a4",  0,1,3'd4, mk(1,0,4,1,0,0,0,0));
    step("a5",  0,1,3'd5, mk(1,0,5,0,0,0,0,0));
    step("arep",0,1,3'd5, mk(0,0,5,0,1,0,0,1));
    step("a6",  0,1,3'd6, mk(1,0,6,0,0,0,0,1));
    step("a7",  0,1,3'd7, mk(1,0,7,1,0,0,0,1));

    // Asynchronous reset mid-lock, overriding clr and in_valid.
    #2;
    reset    = 1'b1;
    clr      = 1'b1;
    in_valid = 1'b1;
    in_code  = 3'd0;
    #1 check_now("arst", mk(0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1 check_now("arsthold", mk(0,0,0,0,0,0,0,0));
    @(negedge clk);
    reset    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    step("post", 0,0,3'd0, mk(0,0,0,0,0,0,0,0));
    step("post2",0,1,3'd4, mk(0,0,4,1,0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/count_seq_decoder.md
COUNT_SEQ_DECODER -- requirements
Module: count_seq_decoder

Interface
REQ-001 SHALL have parameter ERR_W, default 8, width of the saturating error counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port clr, input, 1, synchronous clear; returns the block to IDLE and zeroes err_count.
REQ-005 SHALL have port in_valid, input, 1, marks in_code as one new counter sample this cycle.
REQ-006 SHALL have port in_code, input, 3, sampled 3-bit counter value, binary or Gray sequence.
REQ-007 SHALL have port locked, output, 1, high in state BIN or GRAY.
REQ-008 SHALL have port mode, output, 1, 1 = GRAY locked, 0 otherwise.
REQ-009 SHALL have port dec_value, output, 3, sequence index of the latest sample.
REQ-010 SHALL have port parity_flag, output, 1, XOR of the 3 bits of the latest accepted sample.
REQ-011 SHALL have port seq_err, output, 1, one-cycle pulse on an illegal transition.
REQ-012 SHALL have port mode_chg, output, 1, one-cycle pulse on a BIN<->GRAY switch.
REQ-013 SHALL have port wrap, output, 1, one-cycle pulse when dec_value goes 7 -> 0 while locked.
REQ-014 SHALL have port err_count, output, ERR_W, count of seq_err pulses, saturating.

Function
REQ-015 SHALL define bin_next(x) = (x+1) mod 8.
REQ-016 SHALL define gray_next: 0->1, 1->3, 3->2, 2->6, 6->7, 7->5, 5->4, 4->0.
REQ-017 SHALL hold a registered prev (3 bits) and a 4-state FSM: IDLE, HAVE1, BIN, GRAY.
REQ-018 SHALL update state and outputs only on cycles with in_valid=1; with in_valid=0, state, prev, dec_value and parity_flag hold, and all pulses are 0.
REQ-019 SHALL register all outputs; response appears one clk after the accepting edge.
REQ-020 IDLE + valid: prev<=in_code, go HAVE1, no pulses.
REQ-021 HAVE1 + valid: bin-only match -> BIN; gray-only match -> GRAY; both match (0->1, 6->7) -> stay HAVE1; no match -> seq_err, stay HAVE1; prev<=in_code in all cases.
REQ-022 BIN + valid: bin match -> stay BIN; else gray match -> GRAY with mode_chg; else seq_err, go HAVE1; prev<=in_code.
REQ-023 GRAY + valid: gray match -> stay GRAY; else bin match -> BIN with mode_chg; else seq_err, go HAVE1; prev<=in_code.
REQ-024 A match for the current locked mode SHALL take priority over a switch, so ambiguous transitions never cause mode_chg.
REQ-025 A repeated value (in_code == prev) SHALL be an illegal transition.
REQ-026 dec_value SHALL be the Gray-to-binary conversion of the sample (b2=g2, b1=g2^g1, b0=b1^g0) when the next state is GRAY, otherwise the raw sample.
REQ-027 wrap SHALL pulse when a locked, non-error sample gives dec_value 0 after a previous dec_value of 7 in the same mode.
REQ-028 err_count SHALL increment by 1 per seq_err and saturate at 2^ERR_W-1.
REQ-029 clr SHALL have priority over in_valid in the same cycle: the sample is dropped, state<=IDLE, err_count<=0, pulses 0, dec_value and parity_flag hold.

Reset
REQ-030 reset SHALL asynchronously force state IDLE, prev=0, and locked, mode, dec_value, parity_flag, seq_err, mode_chg, wrap and err_count all 0.
REQ-031 reset SHALL override clr and in_valid; reset asserted mid-sequence discards lock and err_count.

Verification
REQ-032 Valid samples 2,3,4,5,6,7,0 after reset: locked=1 after the sample 3; mode=0; wrap pulses on the sample 0; err_count=0.
REQ-033 Valid samples 0,1,3,2,6,7,5,4,0: locked after the sample 3 with mode=1; dec_value 2,3,4,5,6,7,0; wrap on the final 0.
REQ-034 Binary-locked at 3, then samples 2,6: mode_chg pulse on the sample 2, mode=1, dec_value=3 then 4, seq_err stays 0.
REQ-035 Samples 0,1,5: seq_err pulse on the sample 5, state HAVE1, err_count=1; 300 further illegal samples -> err_count=255 (ERR_W=8).
REQ-036 Samples 0,1 only: locked stays 0 (ambiguous); then clr with in_valid=1 -> IDLE, sample ignored; then reset mid-lock -> all outputs 0 asynchronously.
